// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer: FSM states and the
// select encoding understood by the downstream 8-bit shift register.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // Select value driven while the FSM sits in state st (dir: 1 = left).
    function automatic logic [1:0] sel_for(input state_t st, input logic dir);
        case (st)
            ST_LOAD:  return SEL_LOAD;
            ST_SHIFT: return dir ? SEL_SHL : SEL_SHR;
            default:  return SEL_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/shift_ctrl_counter.sv
// Loadable down-counter holding the remaining shift cycles; last flags value==1.
module shift_ctrl_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             last
);

    logic [CNT_W-1:0] value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign last = (value == CNT_W'(1));

endmodule

// File: rtl/shift_ctrl.sv
// Command sequencer for the 8-bit shift register: one load cycle, then N shifts,
// then a one-cycle done pulse. Optional abort input under SHIFT_CTRL_ABORT_EN.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_count,
`ifdef SHIFT_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] sr_data,
    output logic [1:0]       sr_select,
    output logic             sr_e,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: a command transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and in_valid at any other time is ignored.
    state_t           state;
    state_t           state_nx;
    logic             cap_dir;
    logic [CNT_W-1:0] cap_count;
    logic             cnt_last;
    logic             accept;
    logic             abort_hit;

`ifdef SHIFT_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    shift_ctrl_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (state == ST_LOAD),
        .dec        (state == ST_SHIFT),
        .load_value (cap_count),
        .last       (cnt_last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = (abort_hit || cap_count == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (abort_hit || cnt_last) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sr_data   <= '0;
            cap_dir   <= 1'b0;
            cap_count <= '0;
            sr_select <= SEL_HOLD;
            sr_e      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state <= state_nx;
            if (accept) begin
                sr_data   <= in_data;
                cap_dir   <= in_dir;
                cap_count <= in_count;
            end
            sr_select <= sel_for(state_nx, cap_dir);
            sr_e      <= (state_nx == ST_LOAD) || (state_nx == ST_SHIFT);
            busy      <= (state_nx != ST_IDLE);
            done      <= (state_nx == ST_DONE);
            in_ready  <= (state_nx == ST_IDLE);
        end
    end

endmodule
